// File: rtl/led_stream_decoder_if.sv
// Output bundle of the LED stream decoder: decoded pixels, frame markers and FSM debug state.
// pixel_valid, frame_done and error are push-only pulses with no ready; the consumer samples every cycle,
// and pixel_data/pixel_index/pixel_count hold their values between pulses.
interface led_stream_decoder_if #(
    parameter int MAX_PIXELS = 64
);
    localparam int IW = (MAX_PIXELS > 1) ? $clog2(MAX_PIXELS) : 1;

    logic [23:0] pixel_data;
    logic [IW-1:0] pixel_index;
    logic pixel_valid;
    logic frame_done;
    logic [IW:0] pixel_count;
    logic overflow;
    logic error;
    logic [1:0] dbg_state;

    modport master (
        output pixel_data, pixel_index, pixel_valid, frame_done,
        output pixel_count, overflow, error, dbg_state
    );

    modport slave (
        input pixel_data, pixel_index, pixel_valid, frame_done,
        input pixel_count, overflow, error, dbg_state
    );
endinterface

// File: rtl/led_stream_decoder.sv
// WS2812-style single-wire receive decoder: pulse-width bit recovery, 24-bit GRB pixel assembly, latch detection.
// Optional input glitch filter enabled by defining LED_RX_GLITCH_FILTER_EN.
module led_stream_decoder #(
    parameter int SYS_FREQ_MHZ = 100,
    parameter int THRESH_NS = 625,
    parameter int MIN_HIGH_NS = 150,
    parameter int MAX_HIGH_NS = 1100,
    parameter int RESET_NS = 50000,
    parameter int MAX_PIXELS = 64,
    parameter int GLITCH_CYC = 3
) (
    input logic clk,
    input logic reset,
    input logic din,
    led_stream_decoder_if.master bus
);
    localparam int IW = (MAX_PIXELS > 1) ? $clog2(MAX_PIXELS) : 1;
    localparam logic [15:0] THRESH_C = 16'(SYS_FREQ_MHZ * THRESH_NS / 1000);
    localparam logic [15:0] MIN_C = 16'(SYS_FREQ_MHZ * MIN_HIGH_NS / 1000);
    localparam logic [15:0] MAX_C = 16'(SYS_FREQ_MHZ * MAX_HIGH_NS / 1000);
    localparam logic [15:0] RESET_C = 16'(SYS_FREQ_MHZ * RESET_NS / 1000);
    localparam logic [IW:0] MAXP_C = (IW + 1)'(MAX_PIXELS);

    typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t state_q, state_d;
    logic sync1_q, sync2_q, lvl, lvl_q, rise, fall;
    logic [15:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic pend_q, pend_d;
    logic err_ev, bit_ev, latch_ev, bit_val;
    logic [4:0] bitcnt_q;
    logic [23:0] sr_q, sr_next;
    logic [IW:0] pix_cnt_q;
    logic [23:0] pix_data_q;
    logic [IW-1:0] pix_index_q;
    logic [IW:0] pix_count_q;
    logic pix_valid_q, frame_done_q, overflow_q, error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

`ifdef LED_RX_GLITCH_FILTER_EN
    logic filt_q;
    logic [7:0] gcnt_q;

    // The level flips only once GLITCH_CYC consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b0;
            gcnt_q <= 8'd0;
        end else if (sync2_q == filt_q) begin
            gcnt_q <= 8'd0;
        end else if (gcnt_q == 8'(GLITCH_CYC - 1)) begin
            filt_q <= sync2_q;
            gcnt_q <= 8'd0;
        end else begin
            gcnt_q <= gcnt_q + 8'd1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lvl_q <= 1'b0;
        else lvl_q <= lvl;
    end

    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= SYNC;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: if (!lvl && lcnt_q >= RESET_C) state_d = IDLE;
            IDLE: if (rise || pend_q) state_d = HIGH;
            HIGH: begin
                if (fall) state_d = (hcnt_q < MIN_C) ? SYNC : LOW;
                else if (hcnt_q > MAX_C) state_d = SYNC;
            end
            LOW: begin
                // Latch wins over a simultaneous rise; IDLE picks the rise up via pend_q.
                if (lcnt_q == RESET_C) state_d = IDLE;
                else if (rise) state_d = HIGH;
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        err_ev = 1'b0;
        bit_ev = 1'b0;
        latch_ev = 1'b0;
        pend_d = 1'b0;
        hcnt_d = hcnt_q;
        lcnt_d = lcnt_q;
        case (state_q)
            SYNC: lcnt_d = lvl ? 16'd0 : sat_inc(lcnt_q);
            IDLE: begin
                lcnt_d = 16'd0;
                if (rise || pend_q) hcnt_d = 16'd1;
            end
            HIGH: begin
                hcnt_d = sat_inc(hcnt_q);
                lcnt_d = 16'd0;
                if (fall) begin
                    if (hcnt_q < MIN_C) err_ev = 1'b1;
                    else begin
                        bit_ev = 1'b1;
                        lcnt_d = 16'd1;
                    end
                end else if (hcnt_q > MAX_C) begin
                    err_ev = 1'b1;
                end
            end
            LOW: begin
                lcnt_d = sat_inc(lcnt_q);
                if (lcnt_q == RESET_C) begin
                    latch_ev = 1'b1;
                    pend_d = rise;
                end else if (rise) begin
                    hcnt_d = 16'd1;
                end
            end
            default: ;
        endcase
    end

    assign bit_val = (hcnt_q >= THRESH_C);
    assign sr_next = {sr_q[22:0], bit_val};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q <= 16'd0;
            lcnt_q <= 16'd0;
            pend_q <= 1'b0;
            bitcnt_q <= 5'd0;
            sr_q <= 24'd0;
            pix_cnt_q <= '0;
            pix_data_q <= 24'd0;
            pix_index_q <= '0;
            pix_count_q <= '0;
            pix_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            lcnt_q <= lcnt_d;
            pend_q <= pend_d;
            pix_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            error_q <= 1'b0;
            if (err_ev) begin
                error_q <= 1'b1;
                bitcnt_q <= 5'd0;
                pix_cnt_q <= '0;
                overflow_q <= 1'b0;
            end else if (bit_ev) begin
                sr_q <= sr_next;
                if (bitcnt_q == 5'd23) begin
                    bitcnt_q <= 5'd0;
                    if (pix_cnt_q < MAXP_C) begin
                        pix_data_q <= sr_next;
                        pix_index_q <= pix_cnt_q[IW-1:0];
                        pix_valid_q <= 1'b1;
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end else begin
                    bitcnt_q <= bitcnt_q + 5'd1;
                end
            end else if (latch_ev) begin
                frame_done_q <= 1'b1;
                pix_count_q <= pix_cnt_q;
                pix_cnt_q <= '0;
                overflow_q <= 1'b0;
                bitcnt_q <= 5'd0;
                if (bitcnt_q != 5'd0) error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.pixel_data = pix_data_q;
        bus.pixel_index = pix_index_q;
        bus.pixel_valid = pix_valid_q;
        bus.frame_done = frame_done_q;
        bus.pixel_count = pix_count_q;
        bus.overflow = overflow_q;
        bus.error = error_q;
        bus.dbg_state = state_q;
    end
endmodule

// File: tb/tb_led_stream_decoder.sv
// Self-checking bench for led_stream_decoder; built with a short latch time and 4-pixel frames to keep runs short.
module tb_led_stream_decoder;
    localparam int MAXP = 4;
    localparam int IW = 2;
    localparam int LATCH_WAIT = 2100;
    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    led_stream_decoder_if #(.MAX_PIXELS(MAXP)) bus ();

    led_stream_decoder #(
        .SYS_FREQ_MHZ(100), .THRESH_NS(625), .MIN_HIGH_NS(150), .MAX_HIGH_NS(1100),
        .RESET_NS(20000), .MAX_PIXELS(MAXP), .GLITCH_CYC(3)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .din(din),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: observed events and the reference expectations.
    logic [IW+23:0] obs_pix_q[$];
    logic [IW:0] obs_fd_q[$];
    logic [IW+23:0] exp_q[$];
    logic [IW:0] exp_fd_q[$];
    int err_pulses = 0;
    int err_with_fd = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pixel_valid) obs_pix_q.push_back({bus.pixel_index, bus.pixel_data});
            if (bus.frame_done) obs_fd_q.push_back(bus.pixel_count);
            if (bus.error) begin
                err_pulses++;
                if (bus.frame_done) err_with_fd++;
            end
        end
    end

    task automatic clear_sb();
        obs_pix_q.delete();
        obs_fd_q.delete();
        exp_q.delete();
        exp_fd_q.delete();
        err_pulses = 0;
        err_with_fd = 0;
    endtask

    // Reference model: a frame of n whole pixels yields the first MAXP as indexed words and one frame count.
    task automatic model_frame(input logic [23:0] px[$]);
        int n;
        n = px.size();
        for (int i = 0; i < n; i++)
            if (i < MAXP) exp_q.push_back({IW'(i), px[i]});
        exp_fd_q.push_back((IW + 1)'((n < MAXP) ? n : MAXP));
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        repeat (b ? 80 : 40) @(posedge clk);
        din = 1'b0;
        repeat (b ? 45 : 85) @(posedge clk);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic send_latch();
        din = 1'b0;
        repeat (LATCH_WAIT) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        all_out = {bus.pixel_data, bus.pixel_valid, bus.frame_done, bus.overflow, bus.error, 4'd0};
        n_checks++;
        if (all_out !== 32'd0 || bus.pixel_index !== '0 || bus.pixel_count !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h idx %h cnt %h, expected all 0", all_out, bus.pixel_index, bus.pixel_count);
        end
        n_checks++;
        if (bus.dbg_state !== ST_SYNC) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_SYNC);
        end
        rst_n = 1'b1;
        clear_sb();
        send_latch();
        n_checks++;
        if (bus.dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL sync_to_idle: got %0d expected %0d", bus.dbg_state, ST_IDLE);
        end
        n_checks++;
        if (obs_fd_q.size() != 0 || err_pulses != 0) begin
            n_errors++;
            $display("FAIL sync_no_pulse: got %0d frame_done %0d errors, expected 0 0", obs_fd_q.size(), err_pulses);
        end
    endtask

    task automatic test_single_pixel();
        clear_sb();
        send_pixel(24'h00FF00);
        send_latch();
        n_checks++;
        if (obs_pix_q.size() != 1 || obs_pix_q[0] !== {2'd0, 24'h00FF00}) begin
            n_errors++;
            $display("FAIL single_pixel: got %0d pixels first %h, expected 1 pixel %h",
                     obs_pix_q.size(), (obs_pix_q.size() > 0) ? obs_pix_q[0] : '0, {2'd0, 24'h00FF00});
        end
        n_checks++;
        if (obs_fd_q.size() != 1 || obs_fd_q[0] !== 3'd1) begin
            n_errors++;
            $display("FAIL single_count: got %0d frames, count %0d, expected 1 frame count 1",
                     obs_fd_q.size(), (obs_fd_q.size() > 0) ? obs_fd_q[0] : '0);
        end
        n_checks++;
        if (err_pulses != 0) begin
            n_errors++;
            $display("FAIL single_error: got %0d error pulses expected 0", err_pulses);
        end
    endtask

    task automatic test_frame(input string name, input logic [23:0] px[$]);
        clear_sb();
        model_frame(px);
        foreach (px[i]) send_pixel(px[i]);
        send_latch();
        n_checks++;
        if (obs_pix_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s_npix: got %0d expected %0d", name, obs_pix_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_pix_q[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL %s_pix%0d: got %h expected %h", name, i, obs_pix_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (obs_fd_q.size() != 1 || obs_fd_q[0] !== exp_fd_q[0]) begin
            n_errors++;
            $display("FAIL %s_count: got %0d frames count %0d, expected 1 frame count %0d",
                     name, obs_fd_q.size(), (obs_fd_q.size() > 0) ? obs_fd_q[0] : '0, exp_fd_q[0]);
        end
        n_checks++;
        if (err_pulses != 0 || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_err_ovf: got %0d errors overflow %b, expected 0 0", name, err_pulses, bus.overflow);
        end
    endtask

    task automatic test_three_pixels();
        logic [23:0] px[$];
        px = '{24'hFF0000, 24'h0000FF, 24'h3CFF00};
        test_frame("three", px);
    endtask

    task automatic test_random_frame();
        logic [23:0] px[$];
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) px.push_back(24'($urandom));
        test_frame("random", px);
    endtask

    task automatic test_error_pulse();
        logic [23:0] p;
        clear_sb();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        din = 1'b1;
        repeat (5) @(posedge clk);
        din = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (err_pulses != 1 || bus.dbg_state !== ST_SYNC) begin
            n_errors++;
            $display("FAIL short_pulse: got %0d errors state %0d, expected 1 state %0d", err_pulses, bus.dbg_state, ST_SYNC);
        end
        send_pixel(24'($urandom));
        send_latch();
        n_checks++;
        if (obs_pix_q.size() != 0 || obs_fd_q.size() != 0 || bus.dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL resync_ignore: got %0d pixels %0d frames state %0d, expected 0 0 %0d",
                     obs_pix_q.size(), obs_fd_q.size(), bus.dbg_state, ST_IDLE);
        end
        p = 24'($urandom);
        send_pixel(p);
        send_latch();
        n_checks++;
        if (obs_pix_q.size() != 1 || obs_pix_q[0] !== {2'd0, p} || obs_fd_q.size() != 1) begin
            n_errors++;
            $display("FAIL resync_recover: got %0d pixels %0d frames, expected 1 pixel %h and 1 frame",
                     obs_pix_q.size(), obs_fd_q.size(), {2'd0, p});
        end
    endtask

    task automatic test_overflow();
        logic [23:0] px[$];
        clear_sb();
        for (int i = 0; i < MAXP + 1; i++) px.push_back(24'($urandom));
        model_frame(px);
        for (int i = 0; i < MAXP + 1; i++) begin
            send_pixel(px[i]);
            @(negedge clk);
            n_checks++;
            if (bus.overflow !== (i >= MAXP)) begin
                n_errors++;
                $display("FAIL overflow_after_pix%0d: got %b expected %b", i, bus.overflow, (i >= MAXP));
            end
        end
        send_latch();
        n_checks++;
        if (obs_pix_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL overflow_npix: got %0d expected %0d", obs_pix_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_pix_q[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL overflow_pix%0d: got %h expected %h", i, obs_pix_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (obs_fd_q.size() != 1 || obs_fd_q[0] !== exp_fd_q[0] || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_frame: got %0d frames count %0d ovf %b, expected 1 frame count %0d ovf 0",
                     obs_fd_q.size(), (obs_fd_q.size() > 0) ? obs_fd_q[0] : '0, bus.overflow, exp_fd_q[0]);
        end
    endtask

    task automatic test_partial_frame();
        clear_sb();
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        send_latch();
        n_checks++;
        if (obs_fd_q.size() != 1 || obs_fd_q[0] !== 3'd0 || obs_pix_q.size() != 0) begin
            n_errors++;
            $display("FAIL partial_frame: got %0d frames count %0d pixels %0d, expected 1 frame count 0 pixels 0",
                     obs_fd_q.size(), (obs_fd_q.size() > 0) ? obs_fd_q[0] : '0, obs_pix_q.size());
        end
        n_checks++;
        if (err_pulses != 1 || err_with_fd != 1) begin
            n_errors++;
            $display("FAIL partial_error: got %0d errors %0d with frame_done, expected 1 1", err_pulses, err_with_fd);
        end
    endtask

    task automatic test_reset_mid_pixel();
        clear_sb();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.pixel_valid, bus.frame_done, bus.overflow, bus.error} !== 4'd0 || bus.pixel_data !== 24'd0 ||
            bus.pixel_count !== '0 || bus.dbg_state !== ST_SYNC) begin
            n_errors++;
            $display("FAIL reset_mid: got data %h cnt %0d state %0d, expected zeros and state %0d",
                     bus.pixel_data, bus.pixel_count, bus.dbg_state, ST_SYNC);
        end
        rst_n = 1'b1;
        send_latch();
        n_checks++;
        if (obs_pix_q.size() != 0 || obs_fd_q.size() != 0 || err_pulses != 0 || bus.dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_release: got %0d pixels %0d frames %0d errors state %0d, expected 0 0 0 %0d",
                     obs_pix_q.size(), obs_fd_q.size(), err_pulses, bus.dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_glitch();
        int exp_err;
`ifdef LED_RX_GLITCH_FILTER_EN
        exp_err = 0;
`else
        exp_err = 1;
`endif
        clear_sb();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        din = 1'b1;
        repeat (2) @(posedge clk);
        din = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (err_pulses != exp_err) begin
            n_errors++;
            $display("FAIL glitch_error: got %0d expected %0d", err_pulses, exp_err);
        end
        send_latch();
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_three_pixels();
        test_random_frame();
        test_error_pulse();
        test_overflow();
        test_partial_frame();
        test_reset_mid_pixel();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
